// File: rtl/addr_read_stream_pkg.sv
// rtl/addr_read_stream_pkg.sv - shared types and sizing helpers for addr_read_stream
package addr_read_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // FIFO entry is {last, data}: the last flag sits directly above the data bits
    function automatic int entry_width(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int entry_last_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/addr_read_stream_if.sv
// rtl/addr_read_stream_if.sv - generator, RAM and output-stream signals of addr_read_stream
interface addr_read_stream_if #(
    parameter int bitwidth  = 5,
    parameter int DataWidth = 8
);
    logic                 gen_enable;
    logic [bitwidth-1:0]  in_address;
    logic                 in_nd;
    logic [bitwidth-1:0]  ram_addr;
    logic                 ram_re;
    logic [DataWidth-1:0] ram_rdata;
    logic [DataWidth-1:0] out_data;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output gen_enable, ram_addr, ram_re, out_data, out_last, out_valid,
        input  in_address, in_nd, ram_rdata, out_ready
    );

    modport slave (
        input  gen_enable, ram_addr, ram_re, out_data, out_last, out_valid,
        output in_address, in_nd, ram_rdata, out_ready
    );
endinterface

// File: rtl/addr_read_stream_fifo.sv
// rtl/addr_read_stream_fifo.sv - synchronous FIFO (stream_fifo), power-of-two depth
// Head data reads as zero while empty.
module stream_fifo
    import addr_read_stream_pkg::*;
#(
    parameter int Width = 9,
    parameter int Depth = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push_i,
    input  logic [Width-1:0]   wdata_i,
    input  logic               pop_i,
    output logic [Width-1:0]   rdata_o,
    output logic [ptr_width(Depth):0] count_o,
    output logic               empty_o,
    output logic               full_o
);
    localparam int PW = ptr_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(Depth));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/addr_read_stream.sv
// rtl/addr_read_stream.sv - one start pulse -> one frame of RAM reads streamed out through a FIFO
// Optional sequence checker: ADDR_READ_STREAM_ADDR_CHECK_EN.
module addr_read_stream
    import addr_read_stream_pkg::*;
#(
    parameter int MaxAddress = 20,
    parameter int bitwidth   = 5,
    parameter int DataWidth  = 8,
    parameter int FifoDepth  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    addr_read_stream_if.master  bus,
    output logic                busy,
    output logic                frame_done,
    output logic                addr_err
);
    localparam int EW = entry_width(DataWidth);
    localparam int CW = ptr_width(FifoDepth) + 1;
    localparam logic [bitwidth:0]   MAX_L     = (bitwidth+1)'(MaxAddress);
    localparam logic [bitwidth-1:0] LAST_ADDR = bitwidth'(MaxAddress - 1);
    localparam logic [CW:0]         DEPTH_L   = (CW+1)'(FifoDepth);

    state_e            state_q, state_d;
    logic [bitwidth:0] issued_q, issued_d;
    logic              frame_done_q, frame_done_d;
    logic              rd_valid_q, rd_last_q;
    logic              gen_en;

    logic [EW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [CW:0]   in_flight;

    // Words already committed: buffered, in the RAM stage, or on the generator output
    assign in_flight = {1'b0, fifo_count} + {{CW{1'b0}}, rd_valid_q} + {{CW{1'b0}}, bus.in_nd};

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        frame_done_d = 1'b0;
        gen_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    issued_d = '0;
                end
            end
            ST_RUN: begin
                gen_en = (issued_q < MAX_L) && (in_flight < DEPTH_L);
                if (gen_en) issued_d = issued_q + 1'b1;
                if (issued_q == MAX_L) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.in_nd && !rd_valid_q && fifo_empty) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            issued_q     <= '0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= bus.in_nd;
            rd_last_q    <= (bus.in_address == LAST_ADDR);
        end
    end

    assign fifo_pop  = !fifo_empty && bus.out_ready;
    assign fifo_push = rd_valid_q && (!fifo_full || fifo_pop);

    stream_fifo #(
        .Width (EW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({rd_last_q, bus.ram_rdata}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.gen_enable = gen_en;
    assign bus.ram_addr   = bus.in_address;
    assign bus.ram_re     = bus.in_nd;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_rdata[DataWidth-1:0];
    assign bus.out_last   = fifo_rdata[entry_last_bit(DataWidth)];
    assign busy           = (state_q != ST_IDLE);
    assign frame_done     = frame_done_q;

`ifdef ADDR_READ_STREAM_ADDR_CHECK_EN
    logic [bitwidth-1:0] exp_addr_q;
    logic                addr_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            exp_addr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                exp_addr_q <= '0;
            end else if (bus.in_nd) begin
                exp_addr_q <= (exp_addr_q == LAST_ADDR) ? '0 : exp_addr_q + 1'b1;
            end
            if (bus.in_nd && (bus.in_address != exp_addr_q || state_q == ST_IDLE)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_addr_read_stream.sv
// tb/tb_addr_read_stream.sv - scoreboard bench with generator and RAM models for addr_read_stream
module tb_addr_read_stream;
    localparam int MAX   = 20;
    localparam int BW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef ADDR_READ_STREAM_ADDR_CHECK_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done, addr_err;

    addr_read_stream_if #(.bitwidth(BW), .DataWidth(DW)) bus();

    addr_read_stream #(
        .MaxAddress (MAX),
        .bitwidth   (BW),
        .DataWidth  (DW),
        .FifoDepth  (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .addr_err   (addr_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Address generator: emits sequential addresses one cycle after enable, wrapping at MAX
    logic [BW-1:0] gen_addr;
    int            force_idx = -1;
    logic [BW-1:0] force_val = '0;

    always @(posedge clock) begin
        if (reset) begin
            gen_addr       <= '0;
            bus.in_nd      <= 1'b0;
            bus.in_address <= '0;
        end else begin
            bus.in_nd <= bus.gen_enable;
            if (bus.gen_enable) begin
                bus.in_address <= (int'(gen_addr) == force_idx) ? force_val : gen_addr;
                gen_addr       <= (int'(gen_addr) == MAX - 1) ? '0 : gen_addr + 1'b1;
            end
        end
    end

    // Synchronous RAM whose content is address + 0x40
    always @(posedge clock) begin
        if (bus.ram_re) bus.ram_rdata <= DW'(bus.ram_addr) + 8'h40;
    end

    int ready_mode = 1;
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic [DW:0] exp_q[$];
    logic [DW:0] exp_word;
    logic [DW:0] prev_head;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_fd = 1'b0;
    int cyc = 0;
    int frame_pops = 0, total_pops = 0, done_cnt = 0;
    int ge_total = 0, pop_total = 0, ge_frame = 0, last_pop_cyc = 0;
    int lat_ge = -1, lat_ov = -1;
    bit lat_arm = 1'b0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_fd    = 1'b0;
            ge_total   = 0;
            pop_total  = 0;
        end else begin
            if (bus.gen_enable) begin
                check("throttle_room", 32'(ge_total - pop_total < DEPTH), 1);
                ge_total++;
                ge_frame++;
                if (lat_arm && lat_ge < 0) lat_ge = cyc;
            end
            if (lat_arm && bus.out_valid && lat_ov < 0) lat_ov = cyc;
            if (prev_valid && !prev_ready) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_head", {bus.out_last, bus.out_data}, prev_head);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h required none", {bus.out_last, bus.out_data});
                end else begin
                    exp_word = exp_q.pop_front();
                    check("word", {bus.out_last, bus.out_data}, exp_word);
                end
                frame_pops++;
                total_pops++;
                pop_total++;
                last_pop_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_done_gap", cyc - last_pop_cyc, 2);
                check("frame_done_width", prev_fd, 0);
            end
            prev_fd    = frame_done;
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_head  = {bus.out_last, bus.out_data};
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        logic [DW-1:0] d;
        for (int i = 0; i < MAX; i++) begin
            d = (i == force_idx) ? DW'(force_val) + 8'h40 : DW'(i) + 8'h40;
            exp_q.push_back({(i == MAX - 1), d});
        end
        frame_pops = 0;
        ge_frame   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got done=%0d required %0d", done_cnt, target);
        end
    endtask

    task automatic wait_issued(input int target);
        int n = 0;
        while (ge_frame < target && n < 200) begin
            tick();
            n++;
        end
        check("issue_reached", 32'(ge_frame >= target), 1);
    endtask

    initial begin
        int base, tp, n;

        // 1: reset state, full frame at full throughput, latency
        repeat (3) tick();
        @(negedge clock);
        check("reset_outputs", {bus.gen_enable, bus.ram_re, bus.ram_addr, bus.out_valid,
                                bus.out_data, bus.out_last, busy, frame_done, addr_err}, 0);
        tick();
        reset = 1'b0;
        ready_mode = 1;
        tick();
        lat_arm = 1'b1;
        start_frame();
        wait_done(1, 300);
        lat_arm = 1'b0;
        check("latency", lat_ov - lat_ge, 3);
        check("t1_words", frame_pops, MAX);
        check("t1_busy_after", busy, 0);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: consumer stalled for the whole frame
        ready_mode = 0;
        tick();
        tick();
        start_frame();
        repeat (30) tick();
        @(negedge clock);
        check("t2_gen_enable_low", bus.gen_enable, 0);
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_issued", ge_frame, DEPTH);
        check("t2_no_pops", frame_pops, 0);
        ready_mode = 1;
        wait_done(2, 300);
        check("t2_words", frame_pops, MAX);

        // 3: random backpressure over three back-to-back frames
        ready_mode = 2;
        base = done_cnt;
        tp = total_pops;
        for (int f = 0; f < 3; f++) begin
            start_frame();
            wait_done(base + f + 1, 600);
        end
        check("t3_words", total_pops - tp, 3 * MAX);
        check("t3_done_pulses", done_cnt - base, 3);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: reset mid-frame with reads in flight
        ready_mode = 1;
        tick();
        start_frame();
        wait_issued(7);
        reset = 1'b1;
        tick();
        exp_q.delete();
        @(negedge clock);
        check("t4_reset_outputs", {bus.gen_enable, bus.ram_re, bus.ram_addr, bus.out_valid,
                                   bus.out_data, bus.out_last, busy, frame_done, addr_err}, 0);
        tick();
        reset = 1'b0;
        tick();
        base = done_cnt;
        start_frame();
        wait_done(base + 1, 300);
        check("t4_words", frame_pops, MAX);

        // 5: start during RUN is ignored
        base = done_cnt;
        start_frame();
        wait_issued(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(base + 1, 300);
        check("t5_words", frame_pops, MAX);
        repeat (10) tick();
        check("t5_no_restart", busy, 0);
        check("t5_done_once", done_cnt - base, 1);
        check("t5_queue_empty", exp_q.size(), 0);

        // 6: out-of-sequence address
        force_idx = 6;
        force_val = BW'(9);
        base = done_cnt;
        start_frame();
        n = 0;
        @(negedge clock);
        while (!(bus.in_nd && bus.in_address == BW'(9)) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t6_bad_addr_seen", 32'(n < 100), 1);
        check("t6_err_before", addr_err, 0);
        @(negedge clock);
        check("t6_err_next", addr_err, ERR_EN);
        tick();
        wait_done(base + 1, 300);
        check("t6_err_sticky", addr_err, ERR_EN);
        check("t6_words", frame_pops, MAX);
        force_idx = -1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("t6_err_cleared", addr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
